// File: rtl/icache_fetch_unit_pkg.sv
// icache_fetch_unit_pkg: shared widths, defaults and FSM state encoding for the instruction cache
package icache_fetch_unit_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int DEFAULT_INDEX_BITS = 6;
  typedef enum logic {ICACHE_IDLE = 1'b0, ICACHE_WAIT = 1'b1} icache_state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: direct-mapped tag/data/valid storage with async read, sync write and sync valid clear
module icache_line_array
  import icache_fetch_unit_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_WIDTH-1:0] wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [WORD_WIDTH-1:0] data [LINES];
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index];
  always_ff @(posedge clk_in) begin
    if (!rst_in) valid <= '0;
    else if (wr_en) valid[wr_index] <= 1'b1;
  end
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end
endmodule

// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit: direct-mapped instruction cache with single-word miss handshake to the memory controller
module icache_fetch_unit
  import icache_fetch_unit_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  IF2iCache_valid,
  input  logic [ADDR_W-1:0]     IF2iCache_addr,
  output logic                  iCache2IF_valid,
  output logic [WORD_WIDTH-1:0] iCache2IF_inst,
  output logic                  iCache2IF_ready,
  input  logic                  flush_in,
  output logic                  iCache2memCon_valid,
  output logic [ADDR_W-1:0]     iCache2memCon_address,
  input  logic                  memCon2iCache_done,
  input  logic [WORD_WIDTH-1:0] memCon2iCache_return
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - 2;
  icache_state_t state_q, state_d;
  logic drop_q, drop_d;
  logic if_valid_d, mem_valid_d, fill, hit;
  logic [WORD_WIDTH-1:0] if_inst_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [WORD_WIDTH-1:0] rd_data;
  logic [INDEX_BITS-1:0] rd_index, wr_index;
  logic [TAG_BITS-1:0] req_tag, wr_tag;
  assign rd_index = IF2iCache_addr[INDEX_BITS+1:2];
  assign req_tag = IF2iCache_addr[ADDR_W-1:INDEX_BITS+2];
  assign wr_index = iCache2memCon_address[INDEX_BITS+1:2];
  assign wr_tag = iCache2memCon_address[ADDR_W-1:INDEX_BITS+2];
  assign hit = rd_valid && rd_tag == req_tag;
  assign iCache2IF_ready = state_q == ICACHE_IDLE;
  icache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_lines (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_index(rd_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill && rdy_in && rst_in),
    .wr_index(wr_index),
    .wr_tag  (wr_tag),
    .wr_data (memCon2iCache_return)
  );
  always_comb begin
    state_d = state_q;
    drop_d = drop_q;
    if_valid_d = 1'b0;
    if_inst_d = iCache2IF_inst;
    mem_valid_d = iCache2memCon_valid;
    mem_addr_d = iCache2memCon_address;
    fill = 1'b0;
    if (state_q == ICACHE_IDLE) begin
      if (IF2iCache_valid && !flush_in) begin
        if (hit) begin
          if_valid_d = 1'b1;
          if_inst_d = rd_data;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d = IF2iCache_addr & ~ADDR_W'(3);
          state_d = ICACHE_WAIT;
          drop_d = 1'b0;
        end
      end
    end else begin
      drop_d = drop_q || flush_in;
      if (memCon2iCache_done) begin
        fill = 1'b1;
        mem_valid_d = 1'b0;
        state_d = ICACHE_IDLE;
        drop_d = 1'b0;
        if_valid_d = !drop_q && !flush_in;
        if_inst_d = if_valid_d ? memCon2iCache_return : iCache2IF_inst;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ICACHE_IDLE;
      drop_q <= 1'b0;
      iCache2IF_valid <= 1'b0;
      iCache2IF_inst <= '0;
      iCache2memCon_valid <= 1'b0;
      iCache2memCon_address <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      drop_q <= drop_d;
      iCache2IF_valid <= if_valid_d;
      iCache2IF_inst <= if_inst_d;
      iCache2memCon_valid <= mem_valid_d;
      iCache2memCon_address <= mem_addr_d;
    end
  end
endmodule
